// File: rtl/pll_lock_sequencer.sv
// PLL loop-filter acquisition sequencer: reset, coarse and fine acquisition, lock.
// Gates and scales charge-pump current, detects lock/unlock, timeouts and rail saturation.
module pll_lock_sequencer #(
    parameter int unsigned IW            = 19,
    parameter int unsigned VW            = 10,
    parameter int unsigned LOCK_THRESH   = 64,
    parameter int unsigned LOCK_COUNT    = 32,
    parameter int unsigned UNLOCK_COUNT  = 8,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned ACQ_TIMEOUT   = 4096,
    parameter int unsigned RAIL_CYCLES   = 64,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned FINE_SHIFT    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic signed [IW-1:0] cp_current,
    input  logic [VW-1:0]        lf_voltage,
    output logic                 lf_reset,
    output logic signed [IW-1:0] lf_current,
    output logic                 locked,
    output logic                 fail,
    output logic [2:0]           state
);

    localparam int unsigned QW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned LW = $clog2(UNLOCK_COUNT + 1);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(ACQ_TIMEOUT + 1);
    localparam int unsigned RW = $clog2(RAIL_CYCLES + 1);
    localparam int unsigned YW = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RESET_LF = 3'd1,
        S_COARSE   = 3'd2,
        S_FINE     = 3'd3,
        S_LOCKED   = 3'd4,
        S_FAIL     = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [QW-1:0]        r_quiet;
    logic [QW-1:0]        w_quiet_nxt;
    logic [LW-1:0]        r_loud;
    logic [LW-1:0]        w_loud_nxt;
    logic [SW-1:0]        r_settle;
    logic [SW-1:0]        w_settle_nxt;
    logic [TW-1:0]        r_tmo;
    logic [TW-1:0]        w_tmo_nxt;
    logic [RW-1:0]        r_rail;
    logic [RW-1:0]        w_rail_nxt;
    logic [YW-1:0]        r_retry;
    logic [YW-1:0]        w_retry_nxt;
    logic                 r_lf_reset;
    logic signed [IW-1:0] r_lf_current;
    logic                 r_locked;
    logic                 r_fail;
    logic                 w_lf_reset_nxt;
    logic signed [IW-1:0] w_lf_current_nxt;
    logic                 w_locked_nxt;
    logic                 w_fail_nxt;
    logic                 w_abort;

    logic [IW-1:0]        w_mag;
    logic                 w_quiet;
    logic                 w_at_rail;
    logic signed [IW-1:0] w_cp_shr;
    logic [QW-1:0]        w_quiet_run;
    logic [LW-1:0]        w_loud_run;
    logic [SW-1:0]        w_settle_inc;
    logic [TW-1:0]        w_tmo_run;
    logic [RW-1:0]        w_rail_run;
    logic                 w_quiet_hit;
    logic                 w_unlock;
    logic                 w_tmo_hit;
    logic                 w_rail_hit;
    logic                 w_retry_ok;

    // Unsigned magnitude; the most-negative sample wraps to exactly 2^(IW-1).
    assign w_mag     = cp_current[IW-1] ? ($unsigned(~cp_current) + IW'(1)) : $unsigned(cp_current);
    assign w_quiet   = (w_mag <= IW'(LOCK_THRESH));
    assign w_at_rail = (lf_voltage == '0) || (lf_voltage == '1);
    assign w_cp_shr  = cp_current >>> FINE_SHIFT;

    // Run-length counters advance saturating; a miss clears the run.
    assign w_quiet_run  = !w_quiet ? '0 :
                          (r_quiet == QW'(LOCK_COUNT)) ? r_quiet : r_quiet + QW'(1);
    assign w_loud_run   = w_quiet ? '0 :
                          (r_loud == LW'(UNLOCK_COUNT)) ? r_loud : r_loud + LW'(1);
    assign w_rail_run   = !w_at_rail ? '0 :
                          (r_rail == RW'(RAIL_CYCLES)) ? r_rail : r_rail + RW'(1);
    assign w_tmo_run    = (r_tmo == TW'(ACQ_TIMEOUT)) ? r_tmo : r_tmo + TW'(1);
    assign w_settle_inc = (r_settle == SW'(SETTLE_CYCLES)) ? r_settle : r_settle + SW'(1);

    assign w_quiet_hit = (w_quiet_run == QW'(LOCK_COUNT));
    assign w_unlock    = (w_loud_run == LW'(UNLOCK_COUNT));
    assign w_tmo_hit   = (w_tmo_run == TW'(ACQ_TIMEOUT));
    assign w_rail_hit  = (w_rail_run == RW'(RAIL_CYCLES));
    assign w_retry_ok  = ((32'(r_retry) + 32'd1) < MAX_RETRY);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_quiet      <= '0;
            r_loud       <= '0;
            r_settle     <= '0;
            r_tmo        <= '0;
            r_rail       <= '0;
            r_retry      <= '0;
            r_lf_reset   <= 1'b1;
            r_lf_current <= '0;
            r_locked     <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_quiet      <= w_quiet_nxt;
            r_loud       <= w_loud_nxt;
            r_settle     <= w_settle_nxt;
            r_tmo        <= w_tmo_nxt;
            r_rail       <= w_rail_nxt;
            r_retry      <= w_retry_nxt;
            r_lf_reset   <= w_lf_reset_nxt;
            r_lf_current <= w_lf_current_nxt;
            r_locked     <= w_locked_nxt;
            r_fail       <= w_fail_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_quiet_nxt      = r_quiet;
        w_loud_nxt       = '0;
        w_settle_nxt     = r_settle;
        w_tmo_nxt        = r_tmo;
        w_rail_nxt       = r_rail;
        w_retry_nxt      = r_retry;
        w_abort          = 1'b0;
        w_lf_reset_nxt   = 1'b1;
        w_lf_current_nxt = '0;
        w_locked_nxt     = 1'b0;
        w_fail_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_RESET_LF;
                end
            end
            S_RESET_LF: begin
                if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
                    w_state_nxt = S_COARSE;
                end else begin
                    w_settle_nxt = w_settle_inc;
                end
            end
            S_COARSE, S_FINE: begin
                w_quiet_nxt = w_quiet_run;
                w_tmo_nxt   = w_tmo_run;
                w_rail_nxt  = w_rail_run;
                // Rail abort outranks lock progress, which outranks timeout.
                if (w_rail_hit) begin
                    w_abort = 1'b1;
                end else if (w_quiet_hit) begin
                    w_quiet_nxt = '0;
                    if (r_state == S_COARSE) begin
                        w_state_nxt = S_FINE;
                    end else begin
                        w_state_nxt = S_LOCKED;
                        w_retry_nxt = '0;
                    end
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                end
                if (w_abort) begin
                    if (w_retry_ok) begin
                        w_retry_nxt = r_retry + YW'(1);
                        w_state_nxt = S_RESET_LF;
                    end else begin
                        w_state_nxt = S_FAIL;
                    end
                end
            end
            S_LOCKED: begin
                w_loud_nxt = w_loud_run;
                // Loss of lock re-acquires without resetting the filter.
                if (w_unlock) begin
                    w_state_nxt = S_COARSE;
                    w_loud_nxt  = '0;
                    w_quiet_nxt = '0;
                    w_tmo_nxt   = '0;
                    w_rail_nxt  = '0;
                end
            end
            S_FAIL: begin
                w_state_nxt = S_FAIL;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if ((w_state_nxt == S_RESET_LF) && (r_state != S_RESET_LF)) begin
            w_settle_nxt = '0;
            w_quiet_nxt  = '0;
            w_tmo_nxt    = '0;
            w_rail_nxt   = '0;
        end

        if (!enable) begin
            w_state_nxt  = S_IDLE;
            w_retry_nxt  = '0;
            w_settle_nxt = '0;
            w_quiet_nxt  = '0;
            w_loud_nxt   = '0;
            w_tmo_nxt    = '0;
            w_rail_nxt   = '0;
        end

        // Outputs registered from the state being entered so they align with it.
        case (w_state_nxt)
            S_COARSE: begin
                w_lf_reset_nxt   = 1'b0;
                w_lf_current_nxt = cp_current;
            end
            S_FINE: begin
                w_lf_reset_nxt   = 1'b0;
                w_lf_current_nxt = w_cp_shr;
            end
            S_LOCKED: begin
                w_lf_reset_nxt   = 1'b0;
                w_lf_current_nxt = w_cp_shr;
                w_locked_nxt     = 1'b1;
            end
            S_FAIL: begin
                w_fail_nxt = 1'b1;
            end
            default: begin
                w_lf_reset_nxt = 1'b1;
            end
        endcase
    end

    assign state      = r_state;
    assign lf_reset   = r_lf_reset;
    assign lf_current = r_lf_current;
    assign locked     = r_locked;
    assign fail       = r_fail;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed plan steps plus random traffic, compared each cycle
// against an integer-arithmetic model of the sequencing rules.
module tb_pll_lock_sequencer;

    localparam int unsigned IW = 19;
    localparam int unsigned VW = 10;

    localparam int P_IDLE = 0, P_RESET = 1, P_COARSE = 2, P_FINE = 3, P_LOCKED = 4, P_FAIL = 5;
    localparam int THRESH = 64, LOCKC = 32, UNLOCKC = 8, SETTLE = 16, TMO = 4096, RAILC = 64;
    localparam int MAXR = 3, FSHIFT = 2;

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic signed [IW-1:0] cp_current;
    logic [VW-1:0]        lf_voltage;
    logic                 lf_reset;
    logic signed [IW-1:0] lf_current;
    logic                 locked;
    logic                 fail;
    logic [2:0]           state;

    int checks = 0;
    int errors = 0;

    int m_st, m_quiet, m_loud, m_settle, m_tmo, m_rail, m_retry;
    int m_lfr, m_lfc, m_lock, m_fail;

    pll_lock_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cp_current (cp_current),
        .lf_voltage (lf_voltage),
        .lf_reset   (lf_reset),
        .lf_current (lf_current),
        .locked     (locked),
        .fail       (fail),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int floor_div(input int x, input int d);
        int q;
        q = x / d;
        if ((x % d != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    task automatic clear_counts();
        m_quiet = 0; m_loud = 0; m_settle = 0; m_tmo = 0; m_rail = 0;
    endtask

    // One clock of the sequencing rules applied to the inputs about to be sampled.
    task automatic model_step();
        int  cpv, mag, v, nst;
        bit  q, rl, abort;
        cpv = int'(cp_current);
        v   = int'(lf_voltage);
        if (reset) begin
            m_st = P_IDLE; m_retry = 0; clear_counts();
            m_lfr = 1; m_lfc = 0; m_lock = 0; m_fail = 0;
        end else begin
            mag   = (cpv < 0) ? -cpv : cpv;
            q     = (mag <= THRESH);
            rl    = (v == 0) || (v == 1023);
            nst   = m_st;
            abort = 1'b0;
            if (!enable) begin
                nst = P_IDLE; m_retry = 0; clear_counts();
            end else begin
                case (m_st)
                    P_IDLE: begin nst = P_RESET; clear_counts(); end
                    P_RESET: begin
                        m_settle++;
                        if (m_settle == SETTLE) nst = P_COARSE;
                    end
                    P_COARSE, P_FINE: begin
                        m_tmo++;
                        m_rail  = rl ? m_rail + 1 : 0;
                        m_quiet = q ? m_quiet + 1 : 0;
                        if (m_rail >= RAILC) abort = 1'b1;
                        else if (m_quiet >= LOCKC) begin
                            m_quiet = 0;
                            if (m_st == P_COARSE) nst = P_FINE;
                            else begin nst = P_LOCKED; m_retry = 0; end
                        end else if (m_tmo >= TMO) abort = 1'b1;
                        if (abort) begin
                            if (m_retry + 1 < MAXR) begin
                                m_retry++; nst = P_RESET; clear_counts();
                            end else nst = P_FAIL;
                        end
                    end
                    P_LOCKED: begin
                        m_loud = q ? 0 : m_loud + 1;
                        if (m_loud >= UNLOCKC) begin nst = P_COARSE; clear_counts(); end
                    end
                    default: ;
                endcase
            end
            m_st   = nst;
            m_lfr  = (nst == P_IDLE || nst == P_RESET || nst == P_FAIL) ? 1 : 0;
            m_lock = (nst == P_LOCKED) ? 1 : 0;
            m_fail = (nst == P_FAIL) ? 1 : 0;
            if (nst == P_COARSE) m_lfc = cpv;
            else if (nst == P_FINE || nst == P_LOCKED) m_lfc = floor_div(cpv, 2 ** FSHIFT);
            else m_lfc = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
        if (errors >= 50) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("state", 32'(state), 32'(m_st));
        chk("lf_reset", 32'(lf_reset), 32'(m_lfr));
        chk("lf_current", 32'(lf_current), m_lfc);
        chk("locked", 32'(locked), 32'(m_lock));
        chk("fail", 32'(fail), 32'(m_fail));
    endtask

    function automatic logic signed [IW-1:0] rand_quiet();
        return IW'(int'($urandom_range(128)) - 64);
    endfunction

    function automatic logic signed [IW-1:0] rand_loud();
        int m;
        m = int'($urandom_range(262144, 65));
        if ($urandom_range(1) == 1) m = -m;
        if (m > 262143) m = 262143;
        return IW'(m);
    endfunction

    initial begin
        int n_rl, n_co, n_fi, vburst, lburst;
        reset = 1'b1; enable = 1'b0; cp_current = '0; lf_voltage = 10'd512;
        repeat (3) tick();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_lf_reset", 32'(lf_reset), 32'd1);

        // Startup with constant zero current
        reset = 1'b0; enable = 1'b1;
        n_rl = 0; n_co = 0; n_fi = 0;
        for (int i = 0; i < 200 && state != 3'd4; i++) begin
            tick();
            if (state == 3'd1) n_rl++;
            if (state == 3'd2) n_co++;
            if (state == 3'd3) n_fi++;
        end
        chk("startup_settle_len", 32'(n_rl), 32'd16);
        chk("startup_coarse_len", 32'(n_co), 32'd32);
        chk("startup_fine_len", 32'(n_fi), 32'd32);
        chk("startup_locked", 32'(locked), 32'd1);

        // Fine scaling in LOCKED
        cp_current = -19'sd7; tick();
        chk("scale_m7", 32'(lf_current), -32'sd2);
        cp_current = -19'sd262144; tick();
        chk("scale_min", 32'(lf_current), -32'sd65536);
        cp_current = '0; tick();

        // Loss of lock: a quiet sample breaks the loud run
        for (int i = 0; i < 7; i++) begin cp_current = 19'sd100; tick(); end
        chk("lol_hold7", 32'(locked), 32'd1);
        cp_current = 19'sd5; tick();
        for (int i = 0; i < 7; i++) begin cp_current = -19'sd100; tick(); end
        chk("lol_hold_before8", 32'(locked), 32'd1);
        cp_current = -19'sd100; tick();
        chk("lol_state", 32'(state), 32'd2);
        chk("lol_lf_reset", 32'(lf_reset), 32'd0);

        // Quiet-run break in COARSE; rail starts during the final quiet run
        for (int i = 0; i < 31; i++) begin cp_current = 19'sd10; tick(); end
        chk("qb_echo10", 32'(lf_current), 32'd10);
        cp_current = -19'sd65; tick();
        chk("qb_echo_m65", 32'(lf_current), -32'sd65);
        lf_voltage = 10'd1023;
        for (int i = 0; i < 31; i++) begin cp_current = 19'sd10; tick(); end
        chk("qb_still_coarse", 32'(state), 32'd2);
        tick();
        chk("qb_fine", 32'(state), 32'd3);

        // Rail abort outranks simultaneous lock completion
        cp_current = '0;
        repeat (31) tick();
        chk("rail_fine_hold", 32'(state), 32'd3);
        tick();
        chk("rail_over_lock", 32'(state), 32'd1);
        lf_voltage = 10'd512;
        repeat (16) tick();
        chk("rail_resettle", 32'(state), 32'd2);
        lf_voltage = 10'd1023;
        repeat (32) tick();
        repeat (31) tick();
        enable = 1'b0; tick();
        chk("enable_over_rail", 32'(state), 32'd0);

        // Timeouts exhaust retries, then FAIL
        enable = 1'b1; n_rl = 0; n_co = 0;
        for (int i = 0; i < 13000 && state != 3'd5; i++) begin
            cp_current = rand_loud();
            lf_voltage = 10'($urandom_range(1022, 1));
            tick();
            if (state == 3'd1) n_rl++;
            if (state == 3'd2) n_co++;
        end
        chk("tmo_settle_total", 32'(n_rl), 32'd48);
        chk("tmo_coarse_total", 32'(n_co), 32'd12288);
        chk("tmo_fail", 32'(fail), 32'd1);
        chk("tmo_fail_current", 32'(lf_current), 32'd0);
        repeat (5) tick();
        chk("fail_held", 32'(state), 32'd5);
        enable = 1'b0; tick();
        chk("fail_to_idle", 32'(state), 32'd0);
        enable = 1'b1;
        repeat (17) tick();
        chk("retry_new_coarse", 32'(state), 32'd2);
        repeat (4095) tick();
        chk("retry_pre_timeout", 32'(state), 32'd2);
        tick();
        chk("retry_cleared", 32'(state), 32'd1);

        // Reset mid-attempt
        repeat (5) tick();
        reset = 1'b1; tick();
        chk("midreset_state", 32'(state), 32'd0);
        chk("midreset_lf_reset", 32'(lf_reset), 32'd1);
        reset = 1'b0;

        // Random traffic
        vburst = 0; lburst = 0;
        for (int i = 0; i < 6000; i++) begin
            reset  = ($urandom_range(1499) == 0);
            enable = ($urandom_range(399) != 0);
            if (vburst == 0 && $urandom_range(199) == 0) vburst = int'($urandom_range(90, 40));
            if (vburst > 0) begin
                lf_voltage = ($urandom_range(1) == 1) ? 10'h3FF : 10'h000;
                vburst--;
            end else begin
                lf_voltage = 10'($urandom_range(1022, 1));
            end
            if (lburst == 0 && $urandom_range(299) == 0) lburst = int'($urandom_range(12, 5));
            if (lburst > 0 || $urandom_range(19) == 0) cp_current = rand_loud();
            else cp_current = rand_quiet();
            if (lburst > 0) lburst--;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
